// File: rtl/digit_overlay_ctrl.sv
// Overlays an NDIG-digit decimal value on the VGA stream using the shared 8x16 font ROM.
// New values are double-buffered and only take effect at frame start, so the display never tears.
module digit_overlay_ctrl #(
   parameter int X0       = 256,
   parameter int Y0       = 224,
   parameter int NDIG     = 4,
   parameter int BLANK_LZ = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [9:0]          x,
   input  logic [9:0]          y,
   input  logic                video_on,
   input  logic                frame_start,
   input  logic [4*NDIG-1:0]   digits_in,
   input  logic                digits_valid,
   output logic                digits_ready,
   output logic [10:0]         rom_addr,
   input  logic [7:0]          rom_data,
   output logic                pixel_on,
   output logic                pixel_valid
);

   localparam logic [10:0] X_LO  = 11'(X0);
   localparam logic [10:0] X_HI  = 11'(X0 + 8*NDIG);
   localparam logic [10:0] Y_LO  = 11'(Y0);
   localparam logic [10:0] Y_HI  = 11'(Y0 + 16);
   localparam logic [9:0]  X0_V  = 10'(X0);
   localparam logic [9:0]  Y0_V  = 10'(Y0);

   logic [4*NDIG-1:0] pending_q, pending_d;
   logic [4*NDIG-1:0] active_q, active_d;
   logic              pend_full_q, pend_full_d;
   logic [10:0]       rom_addr_q, rom_addr_d;
   logic              in_box_s1_q, in_box_s1_d, in_box_s2_q, in_box_s2_d;
   logic [2:0]        col_s1_q, col_s1_d, col_s2_q, col_s2_d;
   logic              vid_s1_q, vid_s1_d, vid_s2_q, vid_s2_d;
   logic              pixel_on_q, pixel_on_d;
   logic              pixel_valid_q, pixel_valid_d;

   logic                  accept, commit;
   logic                  in_box;
   logic [9:0]            dx, dy;
   logic [6:0]            dig_idx;
   logic [6:0]            glyph;
   logic [3:0]            nib;
   logic                  lead_zero;
   logic [NDIG-1:0][6:0]  code_arr;

   always_comb begin
      accept      = digits_valid & ~pend_full_q;
      commit      = frame_start & pend_full_q;
      pending_d   = accept ? digits_in : pending_q;
      active_d    = commit ? pending_q : active_q;
      pend_full_d = pend_full_q;
      if (accept)
         pend_full_d = 1'b1;
      else if (commit)
         pend_full_d = 1'b0;
   end

   // Leading-zero run is tracked left to right; bad BCD (0x7F) breaks the run and is never blank.
   always_comb begin
      lead_zero = 1'b1;
      nib       = 4'd0;
      code_arr  = '0;
      for (int i = 0; i < NDIG; i++) begin
         nib       = active_q[4*(NDIG-1-i) +: 4];
         lead_zero = lead_zero & (nib == 4'd0);
         if (nib > 4'd9)
            code_arr[i] = 7'h7F;
         else
            code_arr[i] = 7'h30 + {3'b000, nib};
         if ((BLANK_LZ != 0) && lead_zero && (i != NDIG-1))
            code_arr[i] = 7'h00;
      end
   end

   always_comb begin
      in_box  = video_on && ({1'b0, x} >= X_LO) && ({1'b0, x} < X_HI)
                         && ({1'b0, y} >= Y_LO) && ({1'b0, y} < Y_HI);
      dx      = x - X0_V;
      dy      = y - Y0_V;
      dig_idx = dx[9:3];
      glyph   = 7'h00;
      for (int i = 0; i < NDIG; i++) begin
         if (dig_idx == 7'(i))
            glyph = code_arr[i];
      end
      rom_addr_d    = in_box ? {glyph, dy[3:0]} : 11'h000;
      in_box_s1_d   = in_box;
      col_s1_d      = dx[2:0];
      vid_s1_d      = video_on;
      in_box_s2_d   = in_box_s1_q;
      col_s2_d      = col_s1_q;
      vid_s2_d      = vid_s1_q;
      // rom_data now belongs to the address issued one cycle ago, matching the s2 stage.
      pixel_on_d    = in_box_s2_q & rom_data[3'd7 - col_s2_q];
      pixel_valid_d = vid_s2_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q     <= '0;
         active_q      <= '0;
         pend_full_q   <= 1'b0;
         rom_addr_q    <= 11'h000;
         in_box_s1_q   <= 1'b0;
         in_box_s2_q   <= 1'b0;
         col_s1_q      <= 3'd0;
         col_s2_q      <= 3'd0;
         vid_s1_q      <= 1'b0;
         vid_s2_q      <= 1'b0;
         pixel_on_q    <= 1'b0;
         pixel_valid_q <= 1'b0;
      end else begin
         pending_q     <= pending_d;
         active_q      <= active_d;
         pend_full_q   <= pend_full_d;
         rom_addr_q    <= rom_addr_d;
         in_box_s1_q   <= in_box_s1_d;
         in_box_s2_q   <= in_box_s2_d;
         col_s1_q      <= col_s1_d;
         col_s2_q      <= col_s2_d;
         vid_s1_q      <= vid_s1_d;
         vid_s2_q      <= vid_s2_d;
         pixel_on_q    <= pixel_on_d;
         pixel_valid_q <= pixel_valid_d;
      end
   end

   assign digits_ready = ~pend_full_q;
   assign rom_addr     = rom_addr_q;
   assign pixel_on     = pixel_on_q;
   assign pixel_valid  = pixel_valid_q;

endmodule
